// File: rtl/vga_tmds_encoder.sv
// DVI front end for the Raster VGA generator.
// Recovers data-enable from the raw sync timing and TMDS-encodes the blue,
// green and red channels. The pipeline is fixed at three stages so the data
// symbols, the control tokens, io_de and io_locked stay aligned.
module vga_tmds_encoder #(
  parameter int H_ACTIVE        = 640,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] io_vga_r,
  input  logic [3:0] io_vga_g,
  input  logic [3:0] io_vga_b,
  input  logic       io_vga_hsync,
  input  logic       io_vga_vsync,
  output logic [9:0] io_tmds_r,
  output logic [9:0] io_tmds_g,
  output logic [9:0] io_tmds_b,
  output logic       io_de,
  output logic       io_locked
);

  // Level at which a sync input counts as asserted.
  localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  localparam logic [10:0] H_FIRST = 11'(H_BP);
  localparam logic [10:0] H_LAST  = 11'(H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST = 10'(V_BP);
  localparam logic [9:0]  V_LAST  = 10'(V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  TOK_00  = 10'h354;

  // Number of ones in a byte.
  function automatic logic [3:0] count8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Transition-minimising stage: q_m[8] = 1 means XOR chain, 0 means XNOR.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    use_xnor = (count8(d) > 4'd4) || ((count8(d) == 4'd4) && (d[0] == 1'b0));
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC-balancing stage: returns {next running disparity, 10-bit symbol}.
  function automatic logic [14:0] tmds_disp(input logic [8:0] qm, input logic [4:0] cnt);
    logic [3:0]        ones;
    logic signed [5:0] bal;
    logic signed [5:0] acc;
    logic [9:0]        sym;
    ones = count8(qm[7:0]);
    bal  = $signed({1'b0, ones, 1'b0}) - 6'sd8;   // N1 - N0
    acc  = $signed({cnt[4], cnt});
    if ((cnt == 5'd0) || (ones == 4'd4)) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      acc = qm[8] ? (acc + bal) : (acc - bal);
    end else if ((!cnt[4] && (ones > 4'd4)) || (cnt[4] && (ones < 4'd4))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      acc = acc + (qm[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      acc = acc - (qm[8] ? 6'sd0 : 6'sd2) + bal;
    end
    return {acc[4:0], sym};
  endfunction

  // Control token for C1C0.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      2'b11:   t = 10'h2AB;
      default: t = 10'h354;
    endcase
    return t;
  endfunction

  logic        hs_prev, vs_prev;
  logic [10:0] hcnt, hcnt_next;
  logic [9:0]  vcnt, vcnt_next;
  logic        locked, locked_next;
  logic        end_h, end_v, de_next;

  logic [3:0]  s1_r, s1_g, s1_b;
  logic        s1_hs, s1_vs, s1_de, s1_lk;
  logic [8:0]  s2_qm_r, s2_qm_g, s2_qm_b;
  logic        s2_hs, s2_vs, s2_de, s2_lk;
  logic [4:0]  cnt_r, cnt_g, cnt_b;
  logic [14:0] disp_r, disp_g, disp_b;

  // Sync-end detection and next values of the position counters and DE.
  always_comb begin
    end_h       = (hs_prev == SYNC_ON) && (io_vga_hsync != SYNC_ON);
    end_v       = (vs_prev == SYNC_ON) && (io_vga_vsync != SYNC_ON);
    hcnt_next   = hcnt;
    vcnt_next   = vcnt;
    locked_next = locked;
    if (end_h) begin
      hcnt_next = 11'd0;
    end else if (hcnt != 11'h7FF) begin
      hcnt_next = hcnt + 11'd1;
    end else begin
      hcnt_next = hcnt;
    end
    if (end_v) begin
      vcnt_next = 10'd0;
    end else if (end_h && (vcnt != 10'h3FF)) begin
      vcnt_next = vcnt + 10'd1;
    end else begin
      vcnt_next = vcnt;
    end
    if (end_v) begin
      locked_next = 1'b1;
    end else begin
      locked_next = locked;
    end
    de_next = locked_next &&
              (hcnt_next >= H_FIRST) && (hcnt_next <= H_LAST) &&
              (vcnt_next >= V_FIRST) && (vcnt_next <= V_LAST);
  end

  // Stage 1: sample inputs, advance counters and register DE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_prev <= ~SYNC_ON;
      vs_prev <= ~SYNC_ON;
      hcnt    <= 11'd0;
      vcnt    <= 10'd0;
      locked  <= 1'b0;
      s1_r    <= 4'd0;
      s1_g    <= 4'd0;
      s1_b    <= 4'd0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_lk   <= 1'b0;
    end else begin
      hs_prev <= io_vga_hsync;
      vs_prev <= io_vga_vsync;
      hcnt    <= hcnt_next;
      vcnt    <= vcnt_next;
      locked  <= locked_next;
      s1_r    <= io_vga_r;
      s1_g    <= io_vga_g;
      s1_b    <= io_vga_b;
      s1_hs   <= io_vga_hsync;
      s1_vs   <= io_vga_vsync;
      s1_de   <= de_next;
      s1_lk   <= locked_next;
    end
  end

  // Stage 2: expand 4-bit colour to 8 bits and compute q_m per channel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_qm_r <= 9'd0;
      s2_qm_g <= 9'd0;
      s2_qm_b <= 9'd0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_de   <= 1'b0;
      s2_lk   <= 1'b0;
    end else begin
      s2_qm_r <= qm_encode({s1_r, s1_r});
      s2_qm_g <= qm_encode({s1_g, s1_g});
      s2_qm_b <= qm_encode({s1_b, s1_b});
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_de   <= s1_de;
      s2_lk   <= s1_lk;
    end
  end

  // Stage 3 combinational part: DC balance against each channel's disparity.
  always_comb begin
    disp_r = tmds_disp(s2_qm_r, cnt_r);
    disp_g = tmds_disp(s2_qm_g, cnt_g);
    disp_b = tmds_disp(s2_qm_b, cnt_b);
  end

  // Stage 3: register symbols; blanking sends control tokens and clears disparity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_tmds_r <= TOK_00;
      io_tmds_g <= TOK_00;
      io_tmds_b <= TOK_00;
      io_de     <= 1'b0;
      io_locked <= 1'b0;
      cnt_r     <= 5'd0;
      cnt_g     <= 5'd0;
      cnt_b     <= 5'd0;
    end else begin
      io_de     <= s2_de;
      io_locked <= s2_lk;
      if (s2_de) begin
        io_tmds_r <= disp_r[9:0];
        io_tmds_g <= disp_g[9:0];
        io_tmds_b <= disp_b[9:0];
        cnt_r     <= disp_r[14:10];
        cnt_g     <= disp_g[14:10];
        cnt_b     <= disp_b[14:10];
      end else begin
        io_tmds_r <= TOK_00;
        io_tmds_g <= TOK_00;
        io_tmds_b <= ctrl_token({s2_vs, s2_hs});
        cnt_r     <= 5'd0;
        cnt_g     <= 5'd0;
        cnt_b     <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_tmds_encoder.sv
// Scoreboard bench for vga_tmds_encoder on a shrunken raster.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_vga_tmds_encoder;

  localparam int HA    = 8;
  localparam int HBP   = 4;
  localparam int VA    = 4;
  localparam int VBP   = 3;
  localparam int HSW   = 4;                  // hsync width in clocks
  localparam int LINE  = HSW + HBP + HA + 2;  // 2-clock front porch
  localparam int LINES = VBP + VA + 3;        // 2 vsync lines + 1 porch line

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] io_vga_r = 4'd0, io_vga_g = 4'd0, io_vga_b = 4'd0;
  logic       io_vga_hsync = 1'b1, io_vga_vsync = 1'b1;
  logic [9:0] io_tmds_r, io_tmds_g, io_tmds_b;
  logic       io_de, io_locked;

  vga_tmds_encoder #(
    .H_ACTIVE(HA), .H_BP(HBP), .V_ACTIVE(VA), .V_BP(VBP), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset),
    .io_vga_r(io_vga_r), .io_vga_g(io_vga_g), .io_vga_b(io_vga_b),
    .io_vga_hsync(io_vga_hsync), .io_vga_vsync(io_vga_vsync),
    .io_tmds_r(io_tmds_r), .io_tmds_g(io_tmds_g), .io_tmds_b(io_tmds_b),
    .io_de(io_de), .io_locked(io_locked)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       de;
    logic       lk;
    logic       decode;       // 1: check decoded data, 0: check exact symbols
    logic [9:0] sr, sg, sb;
    logic [7:0] dr, dg, db;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic lk_m = 1'b0;   // expected locked state
  logic vs_m = 1'b1;   // last driven vsync

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [9:0] token(input logic vs, input logic hs);
    logic [9:0] t;
    case ({vs, hs})
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      default: t = 10'h2AB;
    endcase
    return t;
  endfunction

  // Software TMDS decoder (DVI receiver side).
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  // Hand-computed symbols for a line of 0,0 then six 0xF pixels from cnt=0.
  function automatic logic [9:0] frow(input int off);
    logic [9:0] s;
    case (off)
      0:       s = 10'h100;
      1:       s = 10'h3FF;
      2:       s = 10'h200;
      3:       s = 10'h0FF;
      4:       s = 10'h200;
      5:       s = 10'h0FF;
      6:       s = 10'h0FF;
      default: s = 10'h200;
    endcase
    return s;
  endfunction

  // Monitor: compare every due entry against the DUT outputs.
  always @(negedge clock) begin
    if (reset) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("de", int'(io_de), int'(e.de));
        check("locked", int'(io_locked), int'(e.lk));
        if (e.decode) begin
          check("dec_r", int'(tmds_decode(io_tmds_r)), int'(e.dr));
          check("dec_g", int'(tmds_decode(io_tmds_g)), int'(e.dg));
          check("dec_b", int'(tmds_decode(io_tmds_b)), int'(e.db));
        end else begin
          check("sym_r", int'(io_tmds_r), int'(e.sr));
          check("sym_g", int'(io_tmds_g), int'(e.sg));
          check("sym_b", int'(io_tmds_b), int'(e.sb));
        end
      end
    end
  end

  task automatic push_exp(input int due, input logic de, input logic lk, input logic dec,
                          input logic [9:0] sr, input logic [9:0] sg, input logic [9:0] sb,
                          input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    exp_t x;
    x.due = due; x.de = de; x.lk = lk; x.decode = dec;
    x.sr = sr; x.sg = sg; x.sb = sb;
    x.dr = {r, r}; x.dg = {g, g}; x.db = {b, b};
    sbq.push_back(x);
  endtask

  // Drive one pixel clock of input and queue its expected output.
  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic hs, input logic vs, input logic act,
                       input logic exact, input logic [9:0] es);
    logic de;
    @(posedge clock);
    #1;
    io_vga_r = r; io_vga_g = g; io_vga_b = b;
    io_vga_hsync = hs; io_vga_vsync = vs;
    if (vs_m == 1'b0 && vs == 1'b1) lk_m = 1'b1;
    vs_m = vs;
    de = lk_m && act;
    if (!de)
      push_exp(cyc + 3, 1'b0, lk_m, 1'b0, 10'h354, 10'h354, token(vs, hs), r, g, b);
    else if (exact)
      push_exp(cyc + 3, 1'b1, lk_m, 1'b0, es, es, es, r, g, b);
    else
      push_exp(cyc + 3, 1'b1, lk_m, 1'b1, 10'h0, 10'h0, 10'h0, r, g, b);
  endtask

  // Raster frames; vs_en=0 keeps vsync deasserted; stop>=0 ends after that many clocks.
  task automatic frame(input int nlines, input logic vs_en, input int stop);
    int         k;
    int         off;
    logic       act, hs, vs;
    logic [3:0] r, g, b;
    k = 0;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < LINE; x++) begin
        if (stop >= 0 && k == stop) return;
        k++;
        hs  = (x >= HSW);
        vs  = vs_en ? ((y % LINES) >= 2) : 1'b1;
        off = x - (HSW + HBP);
        act = ((y % LINES) >= VBP + 1) && ((y % LINES) <= VBP + VA) && (off >= 0) && (off < HA);
        if (act && off < 2) begin
          drive(4'h0, 4'h0, 4'h0, hs, vs, act, 1'b1, frow(off));
        end else if (act && (y % LINES) == VBP + 1) begin
          drive(4'hF, 4'hF, 4'hF, hs, vs, act, 1'b1, frow(off));
        end else begin
          r = 4'($urandom_range(0, 15));
          g = 4'($urandom_range(0, 15));
          b = 4'($urandom_range(0, 15));
          drive(r, g, b, hs, vs, act, 1'b0, 10'h0);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r"}, int'(io_tmds_r), 32'h354);
    check({tag, "_g"}, int'(io_tmds_g), 32'h354);
    check({tag, "_b"}, int'(io_tmds_b), 32'h354);
    check({tag, "_de"}, int'(io_de), 0);
    check({tag, "_locked"}, int'(io_locked), 0);
  endtask

  // Release reset at a negedge; pipeline flushes zeros for two clocks first.
  task automatic release_reset();
    @(negedge clock);
    #2;
    io_vga_hsync = 1'b1;
    io_vga_vsync = 1'b1;
    reset = 1'b1;
    lk_m = 1'b0;
    vs_m = 1'b1;
    push_exp(cyc + 1, 1'b0, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354, 4'h0, 4'h0, 4'h0);
    push_exp(cyc + 2, 1'b0, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354, 4'h0, 4'h0, 4'h0);
    push_exp(cyc + 3, 1'b0, 1'b0, 1'b0, 10'h354, 10'h354, 10'h2AB, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    // Power-on reset state.
    #12;
    check_reset_outputs("por");
    release_reset();

    // No vsync since reset: hsync toggles, never locked, only control tokens.
    frame(3, 1'b0, -1);

    // Directed blanking tokens, then a one-clock vsync glitch that locks.
    drive(4'h3, 4'h5, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0);  // b=2AB
    drive(4'h3, 4'h5, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0);  // b=154
    drive(4'h3, 4'h5, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0);  // b=0AB
    drive(4'h3, 4'h5, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0);  // lock on glitch end
    drive(4'h3, 4'h5, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);  // b=354

    // Two full frames, then a partial one cut by reset mid-active line.
    frame(2 * LINES, 1'b1, -1);
    frame(LINES, 1'b1, (VBP + 2) * LINE + HSW + HBP + 3);

    @(negedge clock);
    #2;
    reset = 1'b0;
    sbq.delete();
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("held_rst");
    release_reset();
    repeat (4) drive(4'h1, 4'h2, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0);

    repeat (5) @(posedge clock);
    @(negedge clock);
    #1;
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
